prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/prog_loader_if.sv | 21 ++
 rtl/prog_loader_word_packer.sv | 59 +++++
 rtl/prog_loader.sv | 161 ++++++++++++++++
 tb/tb_prog_loader.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the program loader.
// The optional checksum stage is enabled by defining PROG_LOADER_CSUM_EN.
package prog_loader_pkg;

    localparam int MAX_WORDS_DEF = 128;
    localparam int LEN_W         = 16;   // header word count, little-endian
    localparam int HDR_BYTES     = 2;
    localparam int WORD_BYTES    = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_LEN0 = 3'd0;
    localparam state_t ST_LEN1 = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_CSUM = 3'd3;
    localparam state_t ST_DONE = 3'd4;
    localparam state_t ST_ERR  = 3'd5;

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, instruction-memory write port out.
// Handshake: a byte transfers on a rising edge where byte_valid_i and byte_ready_o are both high;
// the source holds byte_i stable while valid is high and ready is low.
interface prog_loader_if #(parameter int ADDR_W = 9);
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wd_o;

    modport slave (
        input  byte_i, byte_valid_i,
        output byte_ready_o, mem_we_o, mem_addr_o, mem_wd_o
    );

    modport master (
        output byte_i, byte_valid_i,
        input  byte_ready_o, mem_we_o, mem_addr_o, mem_wd_o
    );
endinterface

// File: rtl/prog_loader_word_packer.sv
// Assembles little-endian bytes into 32-bit words; word_done_o pulses the cycle after the 4th byte.
module word_packer
    import prog_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        take_i,
    input  logic [7:0]  byte_i,
    output logic        word_last_o,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [1:0]  cnt_q,  cnt_d;
    logic [23:0] sr_q,   sr_d;
    logic [31:0] word_q, word_d;
    logic        done_q, done_d;

    assign word_last_o = take_i && (cnt_q == 2'(WORD_BYTES - 1));
    assign word_o      = word_q;
    assign word_done_o = done_q;

    always_comb begin
        cnt_d  = cnt_q;
        sr_d   = sr_q;
        word_d = word_q;
        done_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (take_i) begin
            if (word_last_o) begin
                word_d = {byte_i, sr_q};
                done_d = 1'b1;
                cnt_d  = '0;
            end else begin
                // Newest byte enters at the top so b0 ends up in the low lane.
                sr_d  = {byte_i, sr_q[23:8]};
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sr_q   <= '0;
            word_q <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            word_q <= word_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program into instruction memory and releases the core when loaded.
// Define PROG_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int ADDR_W    = 9
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    prog_loader_if.slave  bus,
    output logic          cpu_rst_o,
    output logic          done_o,
    output logic          err_o,
    output state_t        state_o
);

    localparam int CNT_W = ADDR_W - 1;   // word index plus guard bit

    state_t            state_q,    state_d;
    logic              ready_q,    ready_d;
    logic [7:0]        len_lo_q,   len_lo_d;
    logic [CNT_W-1:0]  len_q,      len_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              cpu_rst_q,  cpu_rst_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]        csum_q,     csum_d;
`endif

    logic             xfer;
    logic             take;
    logic             restart;
    logic             word_last;
    logic             last_word;
    logic [LEN_W-1:0] len_full;
    logic             len_ok;
    logic [31:0]      word;
    logic             word_done;

    assign xfer      = bus.byte_valid_i && ready_q;
    assign take      = xfer && (state_q == ST_DATA);
    assign restart   = start_i && ((state_q == ST_DONE) || (state_q == ST_ERR));
    assign len_full  = {bus.byte_i, len_lo_q};
    assign len_ok    = (len_full != '0) && (len_full <= LEN_W'(MAX_WORDS));
    assign last_word = (word_cnt_q == len_q - CNT_W'(1));

    word_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (restart),
        .take_i      (take),
        .byte_i      (bus.byte_i),
        .word_last_o (word_last),
        .word_o      (word),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
`ifdef PROG_LOADER_CSUM_EN
        csum_d     = csum_q;
        if (take) csum_d = csum_q ^ bus.byte_i;
`endif
        case (state_q)
            ST_LEN0: if (xfer) begin
                len_lo_d = bus.byte_i;
                state_d  = ST_LEN1;
            end
            ST_LEN1: if (xfer) begin
                if (len_ok) begin
                    len_d   = len_full[CNT_W-1:0];
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_DATA: if (word_last) begin
                addr_d     = {word_cnt_q[ADDR_W-3:0], 2'b00};
                word_cnt_d = word_cnt_q + CNT_W'(1);
                // Leave DATA on the last byte so ready drops before any trailing byte;
                // the final write lands in the first cycle of the next state.
                if (last_word) begin
`ifdef PROG_LOADER_CSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef PROG_LOADER_CSUM_EN
            ST_CSUM: if (xfer) begin
                state_d = (bus.byte_i == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE, ST_ERR: if (start_i) begin
                state_d    = ST_LEN0;
                len_lo_d   = '0;
                len_d      = '0;
                word_cnt_d = '0;
`ifdef PROG_LOADER_CSUM_EN
                csum_d     = '0;
`endif
            end
            default: state_d = ST_LEN0;
        endcase

        ready_d   = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                    (state_d == ST_DATA) || (state_d == ST_CSUM);
        cpu_rst_d = (state_d != ST_DONE);
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERR);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_LEN0;
            ready_q    <= 1'b0;
            len_lo_q   <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef PROG_LOADER_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.byte_ready_o = ready_q;
    assign bus.mem_we_o     = word_done;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_wd_o     = word;
    assign cpu_rst_o        = cpu_rst_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; follows PROG_LOADER_CSUM_EN to pick the checksum or plain flow.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int ADDR_W    = 9;
    localparam int MAX_WORDS = 128;
    localparam int W         = ADDR_W + 32;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   start = 1'b0;
    logic   cpu_rst, done, err;
    state_t st;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .bus       (bus),
        .cpu_rst_o (cpu_rst),
        .done_o    (done),
        .err_o     (err),
        .state_o   (st)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int stalls  = 0;
    int n_writes = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0]  words[MAX_WORDS];
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]   csum_flip = 8'h00;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we_o === 1'b1) begin
            logic [W-1:0] obs;
            logic [W-1:0] e;
            obs = {bus.mem_addr_o, bus.mem_wd_o};
            e   = (exp_q.size() != 0) ? exp_q.pop_front() : ~obs;
            n_writes++;
            check("mem_write", obs, e);
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send_byte(input logic [7:0] b);
        int wait_n = 0;
        bus.byte_i       = b;
        bus.byte_valid_i = 1'b1;
        while (bus.byte_ready_o !== 1'b1 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (wait_n == 20) check("byte_ready_timeout", bus.byte_ready_o, 1'b1);
        else begin
            stalls += wait_n;
            @(negedge clk);
        end
    endtask

    task automatic idle();
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    endtask

    task automatic load(input int n);
`ifdef PROG_LOADER_CSUM_EN
        logic [7:0] cs = 8'h00;
`endif
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({ADDR_W'(4 * k), words[k]});
`ifdef PROG_LOADER_CSUM_EN
            cs = cs ^ words[k][7:0] ^ words[k][15:8] ^ words[k][23:16] ^ words[k][31:24];
`endif
            send_word(words[k]);
        end
`ifdef PROG_LOADER_CSUM_EN
        send_byte(cs ^ csum_flip);
`endif
    endtask

    task automatic restart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_state", st, ST_LEN0);
        check("restart_ready", bus.byte_ready_o, 1'b1);
        check("restart_done", done, 1'b0);
        check("restart_err", err, 1'b0);
        check("restart_cpu_rst", cpu_rst, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, st, ST_LEN0);
        check({tag, "_ready"}, bus.byte_ready_o, 1'b0);
        check({tag, "_we"}, bus.mem_we_o, 1'b0);
        check({tag, "_addr"}, bus.mem_addr_o, '0);
        check({tag, "_wd"}, bus.mem_wd_o, 32'h0);
        check({tag, "_cpu_rst"}, cpu_rst, 1'b1);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wr0;
        bus.byte_i       = 8'h00;
        bus.byte_valid_i = 1'b0;

        // reset and first ready
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        #1 check("ready_before_edge", bus.byte_ready_o, 1'b0);
        @(negedge clk);
        check("ready_after_reset", bus.byte_ready_o, 1'b1);

        // N=2 good load
        words[0] = 32'h0000_2001;
        words[1] = 32'hA000_00FF;
`ifdef PROG_LOADER_CSUM_EN
        csum_flip = 8'h00;
`endif
        load(2);
        idle();
        @(negedge clk);
        check("t1_done", done, 1'b1);
        check("t1_cpu_rst", cpu_rst, 1'b0);
        check("t1_err", err, 1'b0);
        check("t1_ready", bus.byte_ready_o, 1'b0);
        check("t1_writes_left", exp_q.size(), 0);

        // bad lengths
        restart();
        send_byte(8'h00);
        send_byte(8'h00);
        idle();
        check("len0_err", err, 1'b1);
        check("len0_ready", bus.byte_ready_o, 1'b0);
        check("len0_cpu_rst", cpu_rst, 1'b1);
        bus.byte_i = 8'h3C;
        bus.byte_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        idle();
        check("err_holds_state", st, ST_ERR);
        restart();
        send_byte(8'h81);
        send_byte(8'h00);
        idle();
        check("len129_err", err, 1'b1);
        check("len129_ready", bus.byte_ready_o, 1'b0);
        check("len129_done", done, 1'b0);

`ifdef PROG_LOADER_CSUM_EN
        // N=1 with corrupted checksum, then restart
        restart();
        words[0]  = 32'h1234_5678;
        csum_flip = 8'h01;
        load(1);
        idle();
        csum_flip = 8'h00;
        check("badcs_err", err, 1'b1);
        check("badcs_cpu_rst", cpu_rst, 1'b1);
        check("badcs_done", done, 1'b0);
        check("badcs_writes_left", exp_q.size(), 0);
        restart();
`else
        // N=1 without checksum: done after the write, trailing byte refused
        restart();
        words[0] = 32'h1234_5678;
        load(1);
        idle();
        check("nocs_we_now", bus.mem_we_o, 1'b1);
        @(negedge clk);
        check("nocs_done", done, 1'b1);
        check("nocs_cpu_rst", cpu_rst, 1'b0);
        bus.byte_i = 8'h55;
        bus.byte_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("trail_ready", bus.byte_ready_o, 1'b0);
            @(negedge clk);
        end
        idle();
        check("trail_state", st, ST_DONE);
        check("nocs_writes_left", exp_q.size(), 0);
`endif

        // N=MAX_WORDS streamed back-to-back
        restart();
        for (int i = 0; i < MAX_WORDS; i++)
            words[i] = {8'(i), 8'(i * 3), 8'hC3, 8'(255 - i)};
        stalls = 0;
        wr0 = n_writes;
        load(MAX_WORDS);
        idle();
        @(negedge clk);
        check("full_stalls", stalls, 0);
        check("full_writes", n_writes - wr0, MAX_WORDS);
        check("full_done", done, 1'b1);
        check("full_writes_left", exp_q.size(), 0);

        // reset mid-word, then a fresh load
        restart();
        for (int i = 0; i < 4; i++) words[i] = 32'h1111_1111 * (i + 1);
        send_byte(8'h04);
        send_byte(8'h00);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({ADDR_W'(4 * k), words[k]});
            send_word(words[k]);
        end
        send_byte(words[3][7:0]);
        send_byte(words[3][15:8]);
        #1 rst = 1'b1;
        idle();
        #1 check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", bus.byte_ready_o, 1'b1);
        check("midrst_writes_left", exp_q.size(), 0);
        words[0] = 32'hCAFE_F00D;
        load(1);
        idle();
        @(negedge clk);
        check("fresh_done", done, 1'b1);
        check("fresh_err", err, 1'b0);
        check("fresh_writes_left", exp_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
